// File: rtl/onchip_ram_arb_pkg.sv
// Shared constants and the two-way grant function for the on-chip RAM arbiter.
// Port 0 is the Nios data master and port 1 is the DMA/peripheral master.
package onchip_ram_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam bit PRIO_RR    = 1'b0;
    localparam bit PRIO_FIXED = 1'b1;

    // One-hot grant (bit i = port i). A lone requester always wins; a tie goes
    // to port 0 under fixed priority, otherwise to the port not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                           input logic       last,
                                           input bit         fixed);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            if (fixed || (last == PORT1)) gnt = 2'b01;
            else                          gnt = 2'b10;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// Two-way arbiter: combinational one-hot grant from the request pair and the
// last-served port. Grants are forced off while reset_n is low.
module rr_arb2
    import onchip_ram_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = PRIO_RR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_o = 2'b00;
        if (reset_n) grant_o = rr_pick(req_i, last_grant_q, FIXED_PRIO);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i) last_grant_d = grant_o[1];
    end

    // Reset to port 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant_q <= PORT1;
        else          last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters: command mux,
// 1-deep read-owner pipe and read-response demux.
module onchip_ram_arbiter
    import onchip_ram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BE_W       = BE_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              granted;
    logic              sel;
    logic              wr_sel;
    logic              rd_sel;
    logic              rd_accept;

    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [BE_W-1:0]   be_q,    be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_pend_q,  rd_pend_d;
    logic              rd_owner_q, rd_owner_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req),
        .advance_i (granted),
        .grant_o   (grant)
    );

    assign granted        = |grant;
    assign sel            = grant[1];
    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    // A simultaneous read+write on one port is treated as a write only.
    assign wr_sel    = sel ? m1_write : m0_write;
    assign rd_sel    = sel ? m1_read  : m0_read;
    assign rd_accept = granted & rd_sel & ~wr_sel;

    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (granted) begin
            addr_d  = sel ? m1_address    : m0_address;
            be_d    = sel ? m1_byteenable : m0_byteenable;
            wdata_d = sel ? m1_writedata  : m0_writedata;
        end
    end

    assign ram_address    = addr_d;
    assign ram_byteenable = be_d;
    assign ram_writedata  = wdata_d;
    assign ram_chipselect = granted;
    assign ram_write      = granted & wr_sel;
    assign ram_clken      = reset_n;

    always_comb begin
        rd_pend_d  = rd_accept;
        rd_owner_d = rd_owner_q;
        if (rd_accept) rd_owner_d = sel;
    end

    // Async clear of rd_pend_q drops any in-flight response across reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT0;
        end else begin
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_pend_q & (rd_owner_q == PORT0);
    assign m1_readdatavalid = rd_pend_q & (rd_owner_q == PORT1);

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Bench for onchip_ram_arbiter: per-cycle vector table with a read-response
// scoreboard, plus reset and fixed-priority sequences.
module tb_onchip_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata, ram_readdata;

    logic        f_m0_waitrequest, f_m1_waitrequest;
    logic [31:0] f_m0_readdata, f_m1_readdata;
    logic        f_m0_readdatavalid, f_m1_readdatavalid;
    logic [12:0] f_ram_address;
    logic [3:0]  f_ram_byteenable;
    logic        f_ram_chipselect, f_ram_write, f_ram_clken;
    logic [31:0] f_ram_writedata;

    onchip_ram_arbiter #(.FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    onchip_ram_arbiter #(.FIXED_PRIO(1)) u_fix (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
        .m0_readdatavalid(f_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
        .m1_readdatavalid(f_m1_readdatavalid),
        .ram_address(f_ram_address), .ram_byteenable(f_ram_byteenable),
        .ram_chipselect(f_ram_chipselect), .ram_write(f_ram_write),
        .ram_writedata(f_ram_writedata), .ram_clken(f_ram_clken),
        .ram_readdata(32'h0)
    );

    // Behavioural single-port RAM, 1-cycle registered read.
    logic [31:0] mem [8192];
    logic [31:0] ram_q;
    assign ram_readdata = ram_q;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q <= mem[ram_address];
            end
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [12:0] a0;
        logic [31:0] d0;
        logic [3:0]  be0;
        logic        r1, w1;
        logic [12:0] a1;
        logic [31:0] d1;
        logic [3:0]  be1;
        logic        ew0, ew1;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } resp_t;

    vec_t        vecs[$];
    resp_t       exp_q[$];
    logic [31:0] shadow [8192];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(bit r0, bit w0, logic [12:0] a0, logic [31:0] d0, logic [3:0] be0,
                                bit r1, bit w1, logic [12:0] a1, logic [31:0] d1, logic [3:0] be1,
                                bit ew0, bit ew1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.ew0 = ew0; v.ew1 = ew1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        resp_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("rdv0", m0_readdatavalid, r.port == 1'b0);
            check("rdv1", m1_readdatavalid, r.port == 1'b1);
            check("rdata", r.port ? m1_readdata : m0_readdata, r.data);
        end else begin
            check("rdv0_idle", m0_readdatavalid, 1'b0);
            check("rdv1_idle", m1_readdatavalid, 1'b0);
        end
    endtask

    task automatic model_accept(input logic w, input logic r, input logic port,
                                input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        resp_t e;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end else if (r) begin
            e.port = port;
            e.data = shadow[a];
            exp_q.push_back(e);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        check_resp();
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
        #1;
        check("wait0", m0_waitrequest, v.ew0);
        check("wait1", m1_waitrequest, v.ew1);
        check("chipselect", ram_chipselect, !(v.ew0 && v.ew1));
        if (!v.ew0)      model_accept(v.w0, v.r0, 1'b0, v.a0, v.d0, v.be0);
        else if (!v.ew1) model_accept(v.w1, v.r1, 1'b1, v.a1, v.d1, v.be1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]    = 32'h5A5A_0000 ^ (i * 32'h0001_0003);
            shadow[i] = 32'h5A5A_0000 ^ (i * 32'h0001_0003);
        end
        mem[16]  = 32'hDEADBEEF; shadow[16]  = 32'hDEADBEEF;
        mem[256] = 32'hAAAAAAAA; shadow[256] = 32'hAAAAAAAA;
        ram_q = '0;

        // Vectors: r0 w0 a0 d0 be0 | r1 w1 a1 d1 be1 | expected wait0 wait1
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       0,0,13'h000,32'h0,4'h0,        1,1));
        vecs.push_back(mk(1,0,13'h020,32'h0,4'hF,       1,0,13'h030,32'h0,4'hF,        0,1));
        vecs.push_back(mk(1,0,13'h020,32'h0,4'hF,       1,0,13'h030,32'h0,4'hF,        1,0));
        vecs.push_back(mk(1,0,13'h020,32'h0,4'hF,       1,0,13'h030,32'h0,4'hF,        0,1));
        vecs.push_back(mk(1,0,13'h020,32'h0,4'hF,       1,0,13'h030,32'h0,4'hF,        1,0));
        vecs.push_back(mk(1,0,13'h010,32'h0,4'hF,       0,0,13'h000,32'h0,4'h0,        0,1));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       0,0,13'h000,32'h0,4'h0,        1,1));
        vecs.push_back(mk(0,1,13'h100,32'h12345678,4'h3,0,0,13'h000,32'h0,4'h0,        0,1));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       1,0,13'h100,32'h0,4'hF,        1,0));
        vecs.push_back(mk(0,1,13'h040,32'h11111111,4'hF,0,1,13'h041,32'h22222222,4'hF, 0,1));
        vecs.push_back(mk(1,0,13'h041,32'h0,4'hF,       0,1,13'h041,32'h22222222,4'hF, 1,0));
        vecs.push_back(mk(1,0,13'h041,32'h0,4'hF,       1,0,13'h040,32'h0,4'hF,        0,1));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       1,0,13'h040,32'h0,4'hF,        1,0));
        vecs.push_back(mk(1,1,13'h050,32'hCAFEF00D,4'hF,0,0,13'h000,32'h0,4'h0,        0,1));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       1,0,13'h050,32'h0,4'hF,        1,0));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       0,0,13'h000,32'h0,4'h0,        1,1));
        vecs.push_back(mk(0,0,13'h000,32'h0,4'h0,       0,0,13'h000,32'h0,4'h0,        1,1));

        // Reset with a pending read request on port 0.
        reset_n = 1'b0;
        m0_read = 1'b1; m0_write = 1'b0; m0_address = 13'h055; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;      m1_writedata = '0; m1_byteenable = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_wait0", m0_waitrequest, 1'b1);
            check("rst_wait1", m1_waitrequest, 1'b1);
            check("rst_cs", ram_chipselect, 1'b0);
            check("rst_wr", ram_write, 1'b0);
            check("rst_addr", ram_address, 13'h0);
            check("rst_clken", ram_clken, 1'b0);
            check("rst_rdv0", m0_readdatavalid, 1'b0);
            check("rst_rdv1", m1_readdatavalid, 1'b0);
        end
        m0_read = 1'b0;
        reset_n = 1'b1;
        #1 check("clken_run", ram_clken, 1'b1);

        foreach (vecs[i]) apply(vecs[i]);
        @(negedge clk);
        check_resp();
        check("queue_drained", exp_q.size(), 0);

        // Reset asserted right after a read is accepted: response must vanish.
        m0_read = 1'b1; m0_address = 13'h010;
        #1 check("mid_wait0", m0_waitrequest, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rdv0", m0_readdatavalid, 1'b0);
            check("mid_rdv1", m1_readdatavalid, 1'b0);
            check("mid_rst_wait0", m0_waitrequest, 1'b1);
        end
        m0_read = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rdv0", m0_readdatavalid, 1'b0);
            check("post_rdv1", m1_readdatavalid, 1'b0);
        end

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        m0_read = 1'b1; m0_address = 13'h020;
        m1_read = 1'b1; m1_address = 13'h030;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("fix_wait0", f_m0_waitrequest, 1'b0);
            check("fix_wait1", f_m1_waitrequest, 1'b1);
            @(negedge clk);
        end
        m0_read = 1'b0;
        #1;
        check("fix_wait0_idle", f_m0_waitrequest, 1'b1);
        check("fix_wait1_go", f_m1_waitrequest, 1'b0);
        @(negedge clk);
        m1_read = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
